range_stream_gen: RTL and testbench

//  Transmit side of the range-finder sample interface: drives go / data / finish

---
 rtl/range_pkg.sv | 17 +
 rtl/range_sample_src.sv | 38 +++
 rtl/range_stream_gen.sv | 102 ++++++++++
 tb/tb_range_stream_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared constants and FSM state type for the range-finder stimulus generator.
package range_pkg;
  localparam int DATA_W  = 9;
  localparam int RANGE_W = 10;
  localparam int LEN_W   = 8;

  // Fibonacci taps for x^9 + x^5 + 1 (bits 8 and 4 feed back into bit 0)
  localparam logic [DATA_W-1:0] LFSR_TAPS = 9'h110;

  typedef enum logic [2:0] {
    IDLE,
    GO,
    STREAM,
    FINISH,
    CHECK
  } state_t;
endpackage

// File: rtl/range_sample_src.sv
// Sample source: loads the seed on an accepted start and advances by increment or LFSR step.
module range_sample_src
  import range_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sample_next
);
  logic              mode_q;
  logic [DATA_W-1:0] step_val;

  always_comb begin
    step_val = mode_q ? {sample[DATA_W-2:0], ^(sample & LFSR_TAPS)}
                      : sample + DATA_W'(1);
    sample_next = sample;
    if (load) begin
      // an all-zero LFSR would lock up, so substitute all-ones
      sample_next = (mode && (seed == '0)) ? '1 : seed;
    end else if (step) begin
      sample_next = step_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample <= '0;
      mode_q <= 1'b0;
    end else begin
      sample <= sample_next;
      if (load) mode_q <= mode;
    end
  end
endmodule

// File: rtl/range_stream_gen.sv
// Burst generator: drives go/data/finish into a range finder, tracks min/max, checks the returned range.
module range_stream_gen
  import range_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [DATA_W-1:0]  seed,
  input  logic [LEN_W-1:0]   length,
  input  logic [RANGE_W-1:0] range_in,
  output logic               go,
  output logic               finish,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic [RANGE_W-1:0] expected,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output state_t             state
);
  // Handshake: start is a level sampled only in IDLE; go/finish/done/pass/fail are
  // single-cycle pulses and every output is a flop fed from next-state logic.
  state_t            state_d;
  logic              load;
  logic              step;
  logic              sample_cyc;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] min_q, max_q, min_n, max_n;
  logic [DATA_W-1:0] sample, sample_next;

  range_sample_src u_src (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .mode        (mode),
    .seed        (seed),
    .sample      (sample),
    .sample_next (sample_next)
  );

  assign data_out = sample;

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    sample_cyc = (state == GO) || (state == STREAM);
    case (state)
      IDLE: begin
        if (start) begin
          state_d = GO;
          load    = 1'b1;
        end
      end
      GO, STREAM: state_d = ((cnt == LEN_W'(1)) || abort) ? FINISH : STREAM;
      FINISH:     state_d = CHECK;
      CHECK:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    step  = sample_cyc && (state_d == STREAM);
    min_n = (sample_next < min_q) ? sample_next : min_q;
    max_n = (sample_next > max_q) ? sample_next : max_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      min_q    <= '0;
      max_q    <= '0;
      expected <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state  <= state_d;
      go     <= (state_d == GO);
      finish <= (state_d == FINISH);
      busy   <= (state_d != IDLE);
      done   <= (state_d == CHECK);
      // expected is final by FINISH, so range_in is judged on the edge into CHECK
      pass   <= (state_d == CHECK) && (range_in == expected);
      fail   <= (state_d == CHECK) && (range_in != expected);
      if (load) begin
        cnt      <= (length == '0) ? LEN_W'(1) : length;
        min_q    <= sample_next;
        max_q    <= sample_next;
        expected <= '0;
      end else if (step) begin
        cnt      <= cnt - LEN_W'(1);
        min_q    <= min_n;
        max_q    <= max_n;
        expected <= RANGE_W'(max_n - min_n);
      end
    end
  end
endmodule

// File: tb/tb_range_stream_gen.sv
// Self-checking bench for range_stream_gen: sample scoreboard plus per-cycle pulse timing checks.
module tb_range_stream_gen;
  import range_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               mode  = 1'b0;
  logic [DATA_W-1:0]  seed  = '0;
  logic [LEN_W-1:0]   length = '0;
  logic [RANGE_W-1:0] range_in = '0;
  logic               go, finish, busy, done, pass, fail;
  logic [DATA_W-1:0]  data_out;
  logic [RANGE_W-1:0] expected;
  state_t             state;

  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b1;
  bit in_burst = 1'b0;

  range_stream_gen dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .seed     (seed),
    .length   (length),
    .range_in (range_in),
    .go       (go),
    .finish   (finish),
    .data_out (data_out),
    .busy     (busy),
    .expected (expected),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .state    (state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // scoreboard: every sample cycle (go through the cycle before finish) pops one value
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (go) in_burst = 1'b1;
      if (in_burst && !finish) begin
        if (exp_q.size() == 0) check("sample_underflow", 32'(data_out), 32'hFFFF_FFFF);
        else check("data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (finish) in_burst = 1'b0;
    end
  end

  function automatic logic [DATA_W-1:0] model_next(input logic m, input logic [DATA_W-1:0] s);
    logic fb;
    fb = s[8] ^ s[4];
    if (m) return {s[7:0], fb};
    return (s == 9'd511) ? 9'd0 : s + 9'd1;
  endfunction

  // driver: one burst; rin < 0 means answer with the model's range
  task automatic run_burst(input logic m, input logic [DATA_W-1:0] sd, input int len,
                           input int rin, input int abort_k, input bit poke);
    int n_eff, n_sent, exp_range;
    logic [DATA_W-1:0] s, mn, mx;
    bit exp_pass;
    n_eff  = (len == 0) ? 1 : len;
    n_sent = (abort_k >= 0 && abort_k < n_eff) ? abort_k + 1 : n_eff;
    s = (m && sd == 0) ? 9'h1FF : sd;
    mn = s;
    mx = s;
    for (int i = 0; i < n_sent; i++) begin
      exp_q.push_back(s);
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      s = model_next(m, s);
    end
    exp_range = int'(mx) - int'(mn);
    if (rin < 0) rin = exp_range;
    exp_pass = (rin == exp_range);

    @(posedge clock); #1;
    mode = m; seed = sd; length = LEN_W'(len); range_in = RANGE_W'(rin); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    // perturb latched inputs: they must not affect the burst
    seed = DATA_W'($urandom_range(0, 511));
    length = LEN_W'($urandom_range(0, 255));
    for (int c = 1; c <= n_sent + 2; c++) begin
      abort = (c - 1 == abort_k);
      start = poke && (c == 2);
      @(negedge clock);
      check("go", 32'(go), 32'(c == 1));
      check("finish", 32'(finish), 32'(c == n_sent + 1));
      check("done", 32'(done), 32'(c == n_sent + 2));
      check("busy", 32'(busy), 1);
      check("pass", 32'(pass), 32'((c == n_sent + 2) && exp_pass));
      check("fail", 32'(fail), 32'((c == n_sent + 2) && !exp_pass));
      if (c >= n_sent + 1) check("expected", 32'(expected), 32'(exp_range));
      if (c == n_sent + 2) check("queue_empty", 32'(exp_q.size()), 0);
      @(posedge clock); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    @(negedge clock);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_expected_held", 32'(expected), 32'(exp_range));
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_go", 32'(go), 0);
    check("rst_finish", 32'(finish), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_expected", 32'(expected), 0);
    check("rst_done", 32'({done, pass, fail}), 0);
    #1 reset = 1'b0;

    run_burst(1'b0, 9'd10, 5, 4, -1, 1'b0);    // basic increment
    run_burst(1'b0, 9'd510, 4, 511, -1, 1'b0); // wrap, pass
    run_burst(1'b0, 9'd510, 4, 1, -1, 1'b0);   // wrap, fail
    run_burst(1'b0, 9'd7, 0, 0, -1, 1'b0);     // length 0 -> 1
    run_burst(1'b0, 9'd0, 10, 2, 2, 1'b1);     // abort + ignored start
    run_burst(1'b1, 9'd0, 20, -1, -1, 1'b0);   // LFSR with zero seed
    for (int k = 0; k < 4; k++) begin
      run_burst(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 511)),
                $urandom_range(1, 12), ($urandom_range(0, 1) == 1) ? -1 : 0,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1, 1'b0);
    end

    // reset mid-STREAM
    mon_en = 1'b0;
    @(posedge clock); #1;
    mode = 1'b0; seed = 9'd100; length = 8'd10; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_go", 32'(go), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_expected", 32'(expected), 0);
    check("mid_rst_finish", 32'({finish, done, pass, fail}), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      check("post_rst_quiet", 32'({go, finish, done, busy}), 0);
    end
    exp_q.delete();
    in_burst = 1'b0;
    mon_en = 1'b1;
    run_burst(1'b0, 9'd200, 3, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
